// File: rtl/phase_table_sequencer.sv
// phase_table_sequencer
//   Collects decoded phase words into the shadow half of a double-buffered
//   table and plays the committed (active) half out as an AXI-Stream. The
//   banks swap only at a table boundary, so a pass is never torn.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   phase, writeEn      decoded phase word and its write strobe; the falling
//                       edge of writeEn commits the shadow table
//   start, stop         single-cycle playout start / stop pulses
//   loop_en             restart at entry 0 after the last entry
//   m_phase_t*          AXI-Stream master carrying the phase words
//   playing             high whenever the sequencer is not idle
//   active_len          entry count of the bank being played
//   overflow, wr_drop   sticky write-drop flags (shadow full / commit pending)
module phase_table_sequencer #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned PHASE_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PHASE_W-1:0] phase,
   input  logic               writeEn,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   output logic [PHASE_W-1:0] m_phase_tdata,
   output logic               m_phase_tvalid,
   output logic               m_phase_tlast,
   input  logic               m_phase_tready,
   output logic               playing,
   output logic [ADDR_W:0]    active_len,
   output logic               overflow,
   output logic               wr_drop
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      PLAY  = 2'd2
   } state_t;

   // Both banks in one array; the bank bit is the address MSB.
   logic [PHASE_W-1:0] mem_q [2*DEPTH];

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   rd_idx_q, rd_idx_d;
   logic               stop_q, stop_d;
   logic [PHASE_W-1:0] tdata_q, tdata_d;
   logic               tvalid_q, tvalid_d;
   logic               tlast_q, tlast_d;
   logic               playing_q, playing_d;
   logic               we_q, we_d;
   logic [LEN_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic               pending_commit_q, pending_commit_d;
   logic [LEN_W-1:0]   pending_len_q, pending_len_d;
   logic               active_bank_q, active_bank_d;
   logic [LEN_W-1:0]   active_len_q, active_len_d;
   logic               overflow_q, overflow_d;
   logic               wr_drop_q, wr_drop_d;

   logic               mem_we;
   logic [LEN_W-1:0]   mem_waddr;
   logic               handshake;
   logic               swap;
   logic               bank_n;
   logic [LEN_W-1:0]   len_n;
   logic [LEN_W-1:0]   idx_inc;

   assign handshake = tvalid_q & m_phase_tready;
   // A pending table goes live when idle or as the tlast beat is accepted.
   assign swap      = pending_commit_q & ((state_q == IDLE) | (handshake & tlast_q));
   // Bank/length as seen after any swap applied at this edge.
   assign bank_n    = swap ? ~active_bank_q : active_bank_q;
   assign len_n     = swap ? pending_len_q  : active_len_q;
   assign idx_inc   = rd_idx_q + LEN_W'(1);

   // Next-state logic: write path, commit/swap and playout FSM.
   always_comb begin
      state_d          = state_q;
      rd_idx_d         = rd_idx_q;
      stop_d           = stop_q;
      tdata_d          = tdata_q;
      tvalid_d         = tvalid_q;
      tlast_d          = tlast_q;
      we_d             = writeEn;
      wr_ptr_d         = wr_ptr_q;
      pending_commit_d = pending_commit_q;
      pending_len_d    = pending_len_q;
      active_bank_d    = active_bank_q;
      active_len_d     = active_len_q;
      overflow_d       = overflow_q;
      wr_drop_d        = wr_drop_q;
      mem_we           = 1'b0;
      mem_waddr        = {~active_bank_q, wr_ptr_q[ADDR_W-1:0]};

      // Shadow-bank write; a pending commit blocks writes until it swaps.
      if (writeEn) begin
         if (pending_commit_q) begin
            wr_drop_d = 1'b1;
         end else if (wr_ptr_q == LEN_W'(DEPTH)) begin
            overflow_d = 1'b1;
         end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + LEN_W'(1);
         end
      end

      // Falling edge of writeEn closes the table; an empty table is ignored.
      if (we_q && !writeEn && (wr_ptr_q != '0)) begin
         pending_len_d    = wr_ptr_q;
         pending_commit_d = 1'b1;
         wr_ptr_d         = '0;
      end

      if (swap) begin
         active_bank_d    = ~active_bank_q;
         active_len_d     = pending_len_q;
         pending_commit_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            stop_d = 1'b0;
            if (start && !stop && (len_n != '0)) begin
               state_d  = FETCH;
               rd_idx_d = '0;
            end
         end
         FETCH: begin
            if (stop) stop_d = 1'b1;
            tdata_d  = mem_q[{active_bank_q, rd_idx_q[ADDR_W-1:0]}];
            tvalid_d = 1'b1;
            tlast_d  = (active_len_q == LEN_W'(1));
            state_d  = PLAY;
         end
         PLAY: begin
            if (handshake) begin
               if (stop || stop_q) begin
                  state_d  = IDLE;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  stop_d   = 1'b0;
               end else if (!tlast_q) begin
                  // Read ahead so the next word is ready the following cycle.
                  rd_idx_d = idx_inc;
                  tdata_d  = mem_q[{active_bank_q, idx_inc[ADDR_W-1:0]}];
                  tlast_d  = (idx_inc == (active_len_q - LEN_W'(1)));
               end else if (loop_en) begin
                  // Wrap straight into the (possibly freshly swapped) bank.
                  rd_idx_d = '0;
                  tdata_d  = mem_q[{bank_n, ADDR_W'(0)}];
                  tlast_d  = (len_n == LEN_W'(1));
               end else begin
                  state_d  = IDLE;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
               end
            end else if (stop) begin
               stop_d = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
         end
      endcase

      playing_d = (state_d != IDLE);
   end

   // Table storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= phase;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         rd_idx_q         <= '0;
         stop_q           <= 1'b0;
         tdata_q          <= '0;
         tvalid_q         <= 1'b0;
         tlast_q          <= 1'b0;
         playing_q        <= 1'b0;
         we_q             <= 1'b0;
         wr_ptr_q         <= '0;
         pending_commit_q <= 1'b0;
         pending_len_q    <= '0;
         active_bank_q    <= 1'b0;
         active_len_q     <= '0;
         overflow_q       <= 1'b0;
         wr_drop_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         rd_idx_q         <= rd_idx_d;
         stop_q           <= stop_d;
         tdata_q          <= tdata_d;
         tvalid_q         <= tvalid_d;
         tlast_q          <= tlast_d;
         playing_q        <= playing_d;
         we_q             <= we_d;
         wr_ptr_q         <= wr_ptr_d;
         pending_commit_q <= pending_commit_d;
         pending_len_q    <= pending_len_d;
         active_bank_q    <= active_bank_d;
         active_len_q     <= active_len_d;
         overflow_q       <= overflow_d;
         wr_drop_q        <= wr_drop_d;
      end
   end

   assign m_phase_tdata  = tdata_q;
   assign m_phase_tvalid = tvalid_q;
   assign m_phase_tlast  = tlast_q;
   assign playing        = playing_q;
   assign active_len     = active_len_q;
   assign overflow       = overflow_q;
   assign wr_drop        = wr_drop_q;

endmodule

// File: tb/tb_phase_table_sequencer.sv
// Bench for phase_table_sequencer with a 4-entry table (ADDR_W=2) so that
// overflow and full-table cases are reachable in a few cycles.
module tb_phase_table_sequencer;

   localparam int unsigned ADDR_W  = 2;
   localparam int unsigned PHASE_W = 32;

   logic               clk;
   logic               reset;
   logic [PHASE_W-1:0] phase;
   logic               writeEn;
   logic               start;
   logic               stop;
   logic               loop_en;
   logic [PHASE_W-1:0] m_phase_tdata;
   logic               m_phase_tvalid;
   logic               m_phase_tlast;
   logic               m_phase_tready;
   logic               playing;
   logic [ADDR_W:0]    active_len;
   logic               overflow;
   logic               wr_drop;

   phase_table_sequencer #(.ADDR_W(ADDR_W), .PHASE_W(PHASE_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .phase          (phase),
      .writeEn        (writeEn),
      .start          (start),
      .stop           (stop),
      .loop_en        (loop_en),
      .m_phase_tdata  (m_phase_tdata),
      .m_phase_tvalid (m_phase_tvalid),
      .m_phase_tlast  (m_phase_tlast),
      .m_phase_tready (m_phase_tready),
      .playing        (playing),
      .active_len     (active_len),
      .overflow       (overflow),
      .wr_drop        (wr_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] ph;
      logic        st;
      logic        sp;
      logic        lp;
      logic        rdy;
      logic        e_tv;
      logic        e_tl;
      logic        e_pl;
      logic [2:0]  e_len;
      logic [31:0] e_dat;
   } vec_t;

   vec_t        tbl[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] cap_d[$];
   logic        cap_l[$];
   logic [31:0] exp_d[$];
   logic        exp_l[$];
   logic        stall_prev = 1'b0;
   logic [31:0] prev_d = '0;
   logic        prev_l = 1'b0;

   function automatic vec_t mk(input logic we, input logic [31:0] ph, input logic st,
                               input logic sp, input logic lp, input logic rdy,
                               input logic tv, input logic tl, input logic pl,
                               input logic [2:0] len, input logic [31:0] dat);
      vec_t v;
      v.we = we; v.ph = ph; v.st = st; v.sp = sp; v.lp = lp; v.rdy = rdy;
      v.e_tv = tv; v.e_tl = tl; v.e_pl = pl; v.e_len = len; v.e_dat = dat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive tready, check hold-during-stall, record any handshake.
   task automatic cyc(input logic rdy);
      m_phase_tready = rdy;
      if (stall_prev) begin
         chk("stall tvalid held", 32'(m_phase_tvalid), 32'd1);
         chk("stall tdata held", m_phase_tdata, prev_d);
         chk("stall tlast held", 32'(m_phase_tlast), 32'(prev_l));
      end
      if (m_phase_tvalid && rdy) begin
         cap_d.push_back(m_phase_tdata);
         cap_l.push_back(m_phase_tlast);
      end
      stall_prev = m_phase_tvalid && !rdy;
      prev_d     = m_phase_tdata;
      prev_l     = m_phase_tlast;
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [31:0] d, input logic l);
      exp_d.push_back(d);
      exp_l.push_back(l);
   endtask

   task automatic check_beats(input string name);
      chk($sformatf("%s beat count", name), 32'(cap_d.size()), 32'(exp_d.size()));
      for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
         chk($sformatf("%s beat%0d tdata", name, i), cap_d[i], exp_d[i]);
         chk($sformatf("%s beat%0d tlast", name, i), 32'(cap_l[i]), 32'(exp_l[i]));
      end
      cap_d.delete(); cap_l.delete(); exp_d.delete(); exp_l.delete();
   endtask

   task automatic check_reset_state(input string name);
      chk({name, " tvalid"}, 32'(m_phase_tvalid), 32'd0);
      chk({name, " tlast"}, 32'(m_phase_tlast), 32'd0);
      chk({name, " tdata"}, m_phase_tdata, 32'd0);
      chk({name, " playing"}, 32'(playing), 32'd0);
      chk({name, " active_len"}, 32'(active_len), 32'd0);
      chk({name, " overflow"}, 32'(overflow), 32'd0);
      chk({name, " wr_drop"}, 32'(wr_drop), 32'd0);
   endtask

   initial begin
      reset = 1'b1; phase = '0; writeEn = 1'b0; start = 1'b0; stop = 1'b0;
      loop_en = 1'b0; m_phase_tready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;

      //            we  ph     st sp lp rdy  tv tl pl len dat
      // start with an empty table is ignored
      tbl.push_back(mk(0, 32'h0,  1, 0, 0, 1,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  0, 0, 0, 0, 0));
      // load 0x10..0x13, commit, swap two cycles after writeEn falls
      tbl.push_back(mk(1, 32'h10, 0, 0, 0, 1,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 32'h11, 0, 0, 0, 1,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 32'h12, 0, 0, 0, 1,  0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 32'h13, 0, 0, 0, 1,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  0, 0, 0, 4, 0));
      // single pass: tvalid two cycles after start, one beat per cycle
      tbl.push_back(mk(0, 32'h0,  1, 0, 0, 1,  0, 0, 1, 4, 0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  1, 0, 1, 4, 32'h10));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  1, 0, 1, 4, 32'h11));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  1, 0, 1, 4, 32'h12));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  1, 1, 1, 4, 32'h13));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  0, 0, 0, 4, 0));
      // start and stop together: no playout
      tbl.push_back(mk(0, 32'h0,  1, 1, 0, 1,  0, 0, 0, 4, 0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  0, 0, 0, 4, 0));
      tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  0, 0, 0, 4, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         writeEn = tbl[i].we; phase = tbl[i].ph; start = tbl[i].st;
         stop = tbl[i].sp; loop_en = tbl[i].lp; m_phase_tready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d tvalid", i), 32'(m_phase_tvalid), 32'(tbl[i].e_tv));
         chk($sformatf("vec%0d tlast", i), 32'(m_phase_tlast), 32'(tbl[i].e_tl));
         chk($sformatf("vec%0d playing", i), 32'(playing), 32'(tbl[i].e_pl));
         chk($sformatf("vec%0d active_len", i), 32'(active_len), 32'(tbl[i].e_len));
         if (tbl[i].e_tv) chk($sformatf("vec%0d tdata", i), m_phase_tdata, tbl[i].e_dat);
      end
      writeEn = 1'b0; start = 1'b0; stop = 1'b0;

      // Looping with tready toggling, stop latched during a stall
      stall_prev = 1'b0;
      loop_en = 1'b1; start = 1'b1; cyc(0); start = 1'b0;
      chk("loop playing after start", 32'(playing), 32'd1);
      cyc(0);
      chk("loop tvalid latency", 32'(m_phase_tvalid), 32'd1);
      for (int i = 0; i < 12; i++) cyc((i % 2) == 0);
      stop = 1'b1; cyc(0); stop = 1'b0;
      cyc(1);
      chk("stop tvalid low", 32'(m_phase_tvalid), 32'd0);
      chk("stop playing low", 32'(playing), 32'd0);
      cyc(1); cyc(1);
      push_exp(32'h10, 0); push_exp(32'h11, 0); push_exp(32'h12, 0); push_exp(32'h13, 1);
      push_exp(32'h10, 0); push_exp(32'h11, 0); push_exp(32'h12, 0);
      check_beats("loop_stop");

      // Reload while looping: swap happens only at the tlast boundary
      loop_en = 1'b1; start = 1'b1; cyc(1); start = 1'b0; cyc(1);
      writeEn = 1'b1; phase = 32'hA0; cyc(1);
      phase = 32'hA1; cyc(1);
      writeEn = 1'b0; cyc(1);
      chk("reload len before boundary", 32'(active_len), 32'd4);
      cyc(1); cyc(1); cyc(1);
      loop_en = 1'b0;
      cyc(1); cyc(1); cyc(1);
      chk("reload active_len", 32'(active_len), 32'd2);
      chk("reload tvalid low", 32'(m_phase_tvalid), 32'd0);
      chk("reload playing low", 32'(playing), 32'd0);
      push_exp(32'h10, 0); push_exp(32'h11, 0); push_exp(32'h12, 0); push_exp(32'h13, 1);
      push_exp(32'hA0, 0); push_exp(32'hA1, 1); push_exp(32'hA0, 0); push_exp(32'hA1, 1);
      check_beats("reload");

      // Overflow: six writes into a four-entry shadow bank
      for (int i = 0; i < 6; i++) begin
         writeEn = 1'b1; phase = 32'hB0 + 32'(i); cyc(1);
         if (i == 3) chk("overflow not yet", 32'(overflow), 32'd0);
      end
      writeEn = 1'b0; cyc(1); cyc(1);
      chk("overflow set", 32'(overflow), 32'd1);
      chk("full table len", 32'(active_len), 32'd4);
      start = 1'b1; cyc(1); start = 1'b0;
      repeat (6) cyc(1);
      push_exp(32'hB0, 0); push_exp(32'hB1, 0); push_exp(32'hB2, 0); push_exp(32'hB3, 1);
      check_beats("full");

      // Write while a commit is pending is dropped; empty commit ignored
      writeEn = 1'b1; phase = 32'hC0; cyc(1);
      writeEn = 1'b0; cyc(1);
      chk("wr_drop not yet", 32'(wr_drop), 32'd0);
      writeEn = 1'b1; phase = 32'hC1; cyc(1);
      writeEn = 1'b0; cyc(1); cyc(1);
      chk("wr_drop set", 32'(wr_drop), 32'd1);
      chk("one-entry len", 32'(active_len), 32'd1);

      // One-entry loop, then reset in the middle of playout
      loop_en = 1'b1; start = 1'b1; cyc(1); start = 1'b0;
      cyc(1); cyc(1); cyc(1);
      reset = 1'b1; cyc(0); reset = 1'b0;
      stall_prev = 1'b0;
      push_exp(32'hC0, 1); push_exp(32'hC0, 1);
      check_beats("single_loop");
      check_reset_state("mid-play reset");
      loop_en = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
      cyc(1); cyc(1);
      chk("post-reset start tvalid", 32'(m_phase_tvalid), 32'd0);
      chk("post-reset start playing", 32'(playing), 32'd0);
      check_beats("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_table_sequencer.md
Name: phase_table_sequencer

Overview:
- Downstream consumer of the scheduler's payload decoder. Collects decoded phase words (phase/writeEn) into a double-buffered phase table.
- Plays the committed table out as an AXI-Stream of phase words to the phase-shifter datapath, once or looped, on a start command.
- New tables load into the shadow bank while the active bank plays. Bank swaps occur only at table boundaries, so a pass is never torn.

Parameters:
- ADDR_W, 10, table address width; DEPTH = 2**ADDR_W entries per bank.
- PHASE_W, 32, phase word width; matches decoder output.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- phase  in  PHASE_W  decoded phase word
- writeEn  in  1  one table entry per cycle while high; the 1->0 edge marks end of table
- start  in  1  single-cycle pulse: begin playout
- stop  in  1  single-cycle pulse: end playout after the current beat
- loop_en  in  1  level: restart at index 0 after the last entry
- m_phase_tdata  out  PHASE_W  playout phase word
- m_phase_tvalid  out  1  AXI-S valid
- m_phase_tlast  out  1  high on the last table entry of each pass
- m_phase_tready  in  1  AXI-S ready
- playing  out  1  high when not in IDLE
- active_len  out  ADDR_W+1  entry count of the active bank
- overflow  out  1  sticky: write dropped because the shadow bank was full
- wr_drop  out  1  sticky: write dropped while a commit was pending

Behaviour:
- Reset values: all outputs 0; wr_ptr=0; active_bank=0; pending_commit=0; state=IDLE. RAM contents are not cleared. Reset mid-playout drops tvalid on the next cycle; no tlast is owed.
- Write path:
  - Each cycle with writeEn=1, pending_commit=0 and wr_ptr<DEPTH: shadow[wr_ptr]<=phase, wr_ptr++.
  - If wr_ptr==DEPTH: the word is dropped and overflow<=1.
  - If pending_commit=1: the word is dropped and wr_drop<=1.
- Commit: on a writeEn 1->0 edge (registered previous value) with wr_ptr>0: pending_len<=wr_ptr, pending_commit<=1, wr_ptr<=0. The edge with wr_ptr==0 is ignored.
- Swap when pending_commit=1 and either:
  - state==IDLE: swap on the cycle after the commit; or
  - on the handshake of the tlast beat.
- Swap action: active_bank toggles, active_len<=pending_len, pending_commit<=0.
- Length is ADDR_W+1 bits wide, so a full table (DEPTH) is representable.
- States:
  - IDLE: start=1, stop=0, and active_len>0 (after any same-cycle swap) -> FETCH, rd_idx=0. Otherwise start is ignored.
  - FETCH: RAM read latency 1 cycle -> PLAY. m_phase_tvalid rises exactly 2 cycles after start is sampled.
  - PLAY:
    - m_phase_tdata = active[rd_idx]; m_phase_tlast = (rd_idx==active_len-1).
    - On handshake, not last: rd_idx++, next word presented the following cycle. Sustained 1 beat/cycle with tready held high (read-ahead plus skid).
    - On handshake, last, loop_en=1 and no stop latched: rd_idx=0, swap if pending, continue with at most a 2-cycle bubble.
    - On handshake, last, otherwise: -> IDLE.
- AXI-S rules: tvalid, tdata and tlast are held stable until handshake. tvalid never drops without a handshake, except on reset.
- Stop:
  - A stop pulse in FETCH/PLAY is latched. The beat currently presented (or about to be) completes its handshake, then -> IDLE. No further beats follow.
  - Stop in IDLE is ignored. start and stop in the same cycle: stop wins.
- loop_en is sampled at each tlast handshake.
- Simultaneous writeEn falling edge and tlast handshake: the commit is registered this cycle and the swap is applied at the next tlast, or immediately if the block drops to IDLE.

Test Plan:
- Load 4 words 0x10..0x13 (writeEn high 4 cycles) -> active_len=4 two cycles after writeEn falls. start, tready=1 -> tvalid 2 cycles later; beats 0x10,0x11,0x12,0x13 on consecutive cycles; tlast on 0x13; playing falls.
- Same table, loop_en=1, tready toggling 1/0 -> sequence repeats 0x10..0x13 with data stable during stalls. Assert stop mid-pass -> exactly one more beat, then tvalid=0 and IDLE.
- Looping on a 4-word table while loading 2 words 0xA0,0xA1 -> current pass finishes 0x13 with tlast, next pass is 0xA0,0xA1, active_len=2, no torn pass.
- ADDR_W=2, write 6 words -> active_len=4, overflow=1, playout 4 words. Write during pending commit -> wr_drop=1.
- start with active_len=0 -> stays IDLE, tvalid=0. start+stop same cycle -> no playout.
- Assert reset mid-PLAY -> next cycle all outputs 0, active_len=0. start with no reload -> no output.
